// File: rtl/candy_pc_pkg.sv
// -----------------------------------------------------------------------------
// candy_pc_pkg
//   Shared definitions for the candy core instruction-fetch PC unit.
//   - pc_state_t : fetch FSM state encoding (2 bits)
//   - PC_RESET_VEC / PC_STEP_DEF / PC_BOOT_DELAY_DEF : default parameter values
// -----------------------------------------------------------------------------
package candy_pc_pkg;

  typedef enum logic [1:0] {
    PC_ST_BOOT = 2'd0,
    PC_ST_IDLE = 2'd1,
    PC_ST_REQ  = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_RESET_VEC      = 32'h0000_0000;
  localparam int          PC_STEP_DEF       = 4;
  localparam int          PC_BOOT_DELAY_DEF = 2;

endpackage

// File: rtl/candy_pc_redirect_buf.sv
// -----------------------------------------------------------------------------
// candy_pc_redirect_buf
//   Holds the pending redirect for the fetch unit: aligns incoming targets,
//   remembers the latest target seen while a request is outstanding, and
//   flags that outstanding request as wrong-path (kill).
// Ports
//   clk             in   clock
//   rst             in   asynchronous reset, active-low
//   redirect_valid  in   redirect pulse, already qualified (not during boot)
//   redirect_target in   raw redirect address
//   capture         in   redirect arrived while a request waits for its ack
//   clear           in   outstanding request acked this cycle
//   kill            out  outstanding request is on the wrong path
//   redir_addr      out  address to fetch next when a redirect takes effect
// -----------------------------------------------------------------------------
module candy_pc_redirect_buf
  import candy_pc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int STEP   = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              capture,
  input  logic              clear,
  output logic              kill,
  output logic [ADDR_W-1:0] redir_addr
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP) - ADDR_W'(1));

  // Instruction addresses are STEP-aligned; drop the sub-instruction bits.
  function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] t);
    return t & ALIGN_MASK;
  endfunction

  logic [ADDR_W-1:0] saved_tgt;

  // Kill flag: set by a redirect while waiting, cleared when the ack retires
  // the doomed request. capture and clear never coincide (capture needs !ack).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kill <= 1'b0;
    end else if (clear) begin
      kill <= 1'b0;
    end else if (capture) begin
      kill <= 1'b1;
    end
  end

  // Target storage is data only; it is always written before kill can be seen.
  // Later redirects overwrite earlier ones, so the last target wins.
  always_ff @(posedge clk) begin
    if (capture) begin
      saved_tgt <= align_target(redirect_target);
    end
  end

  // A redirect arriving this very cycle supersedes anything stored.
  assign redir_addr = redirect_valid ? align_target(redirect_target) : saved_tgt;

endmodule

// File: rtl/candy_pc_unit.sv
// -----------------------------------------------------------------------------
// candy_pc_unit
//   Instruction-fetch address generator for the candy core IF stage.
//   After a boot delay it issues requests to the instruction SRAM with a
//   req/ack handshake, steps the address by STEP per delivered instruction,
//   and follows EX-stage redirects, discarding a request that was already in
//   flight when the redirect arrived.
// Parameters
//   ADDR_W      address width
//   RESET_VEC   first fetch address after reset
//   STEP        byte increment per instruction (power of two)
//   BOOT_DELAY  enabled cycles spent in BOOT before the first request (>=1)
// Ports
//   clk              in   clock, all state on posedge
//   rst              in   asynchronous reset, active-low
//   pc_enable        in   global fetch enable
//   stall            in   blocks launching a new request
//   redirect_valid   in   one-cycle redirect pulse
//   redirect_target  in   redirect address (aligned internally)
//   fetch_req        out  request to instruction SRAM
//   fetch_addr       out  address of the current/next request
//   fetch_ack        in   SRAM served the request
//   pc               out  address of the most recently delivered instruction
//   pc_valid         out  one-cycle pulse: pc newly updated on the right path
// -----------------------------------------------------------------------------
module candy_pc_unit
  import candy_pc_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(PC_RESET_VEC),
  parameter int                STEP       = PC_STEP_DEF,
  parameter int                BOOT_DELAY = PC_BOOT_DELAY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_enable,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid
);

  localparam int                CNT_W     = $clog2(BOOT_DELAY + 1);
  localparam logic [CNT_W-1:0]  BOOT_INIT = CNT_W'(BOOT_DELAY);
  localparam logic [ADDR_W-1:0] STEP_V    = ADDR_W'(STEP);

  pc_state_t         state;
  logic [CNT_W-1:0]  boot_cnt;
  logic              kill;
  logic [ADDR_W-1:0] redir_addr;
  logic              redir_live;
  logic              in_req;
  logic              ack_in_req;
  logic              go;
  logic              killed_ack;

  // Redirects are meaningless until the core has finished booting.
  assign redir_live = redirect_valid && (state != PC_ST_BOOT);
  assign in_req     = (state == PC_ST_REQ);
  assign ack_in_req = in_req && fetch_ack;
  assign go         = pc_enable && !stall;

  // An ack is discarded if the request was already marked wrong-path, or if a
  // redirect lands in the same cycle (the redirect wins).
  assign killed_ack = ack_in_req && (kill || redirect_valid);

  candy_pc_redirect_buf #(
    .ADDR_W (ADDR_W),
    .STEP   (STEP)
  ) u_redirect_buf (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redir_live),
    .redirect_target (redirect_target),
    .capture         (redir_live && in_req && !fetch_ack),
    .clear           (ack_in_req),
    .kill            (kill),
    .redir_addr      (redir_addr)
  );

  // Fetch FSM. fetch_req is a registered copy of "next state is REQ", so it
  // only falls on an ack edge (or reset) and is never dropped by stall or
  // pc_enable while a request is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PC_ST_BOOT;
      boot_cnt   <= BOOT_INIT;
      fetch_req  <= 1'b0;
      fetch_addr <= RESET_VEC;
      pc         <= RESET_VEC;
      pc_valid   <= 1'b0;
    end else begin
      pc_valid <= 1'b0;
      case (state)
        PC_ST_BOOT: begin
          if (pc_enable) begin
            boot_cnt <= boot_cnt - CNT_W'(1);
            if (boot_cnt == CNT_W'(1)) begin
              state <= PC_ST_IDLE;
            end
          end
        end

        PC_ST_IDLE: begin
          if (redir_live) begin
            fetch_addr <= redir_addr;
          end
          if (go) begin
            state     <= PC_ST_REQ;
            fetch_req <= 1'b1;
          end
        end

        PC_ST_REQ: begin
          if (fetch_ack) begin
            if (killed_ack) begin
              fetch_addr <= redir_addr;
            end else begin
              pc         <= fetch_addr;
              pc_valid   <= 1'b1;
              fetch_addr <= fetch_addr + STEP_V;  // wraps modulo 2^ADDR_W
            end
            // Back-to-back requests when allowed, otherwise rest in IDLE.
            if (!go) begin
              state     <= PC_ST_IDLE;
              fetch_req <= 1'b0;
            end
          end
        end

        default: begin
          state     <= PC_ST_BOOT;
          fetch_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_candy_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_candy_pc_unit
//   Self-checking bench for candy_pc_unit: a cycle table for the 32-bit
//   default instance, hand sequences for async reset and the 8-bit wrap
//   instance, and a randomized run against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_candy_pc_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit default instance
  logic        rst, en, st, rv, ack;
  logic [31:0] rt;
  logic        req, pcv;
  logic [31:0] addr, pc;

  // 8-bit wrapping instance
  logic        rst8, en8, st8, rv8, ack8;
  logic [7:0]  rt8;
  logic        req8, pcv8;
  logic [7:0]  addr8, pc8;

  int n_cmp = 0;
  int n_bad = 0;

  candy_pc_unit dut (
    .clk             (clk),
    .rst             (rst),
    .pc_enable       (en),
    .stall           (st),
    .redirect_valid  (rv),
    .redirect_target (rt),
    .fetch_req       (req),
    .fetch_addr      (addr),
    .fetch_ack       (ack),
    .pc              (pc),
    .pc_valid        (pcv)
  );

  candy_pc_unit #(
    .ADDR_W     (8),
    .RESET_VEC  (8'hFC),
    .STEP       (4),
    .BOOT_DELAY (2)
  ) dut8 (
    .clk             (clk),
    .rst             (rst8),
    .pc_enable       (en8),
    .stall           (st8),
    .redirect_valid  (rv8),
    .redirect_target (rt8),
    .fetch_req       (req8),
    .fetch_addr      (addr8),
    .fetch_ack       (ack8),
    .pc              (pc8),
    .pc_valid        (pcv8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic e_req, input logic [31:0] e_addr,
                      input logic [31:0] e_pc, input logic e_pcv);
    chk({nm, ".req"},  32'(req),  32'(e_req));
    chk({nm, ".addr"}, addr,      e_addr);
    chk({nm, ".pc"},   pc,        e_pc);
    chk({nm, ".pcv"},  32'(pcv),  32'(e_pcv));
  endtask

  task automatic chk8(input string nm, input logic e_req, input logic [7:0] e_addr,
                      input logic [7:0] e_pc, input logic e_pcv);
    chk({nm, ".req"},  32'(req8),  32'(e_req));
    chk({nm, ".addr"}, 32'(addr8), 32'(e_addr));
    chk({nm, ".pc"},   32'(pc8),   32'(e_pc));
    chk({nm, ".pcv"},  32'(pcv8),  32'(e_pcv));
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    bit          en, st, rv;
    logic [31:0] rt;
    bit          ack;
    bit          e_req;
    logic [31:0] e_addr, e_pc;
    bit          e_pcv;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit i_en, input bit i_st, input bit i_rv, input logic [31:0] i_rt,
                     input bit i_ack, input bit o_req, input logic [31:0] o_addr,
                     input logic [31:0] o_pc, input bit o_pcv);
    vec_t v;
    v.en = i_en; v.st = i_st; v.rv = i_rv; v.rt = i_rt; v.ack = i_ack;
    v.e_req = o_req; v.e_addr = o_addr; v.e_pc = o_pc; v.e_pcv = o_pcv;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Abstract view: how many enabled boot cycles remain, whether a request is
  // outstanding, whether that request is doomed by a redirect, where the next
  // fetch goes, and what was last delivered.
  int          m_boot;
  bit          m_busy, m_doomed, m_pcv;
  logic [31:0] m_addr, m_tgt, m_pc;

  task automatic model_reset();
    m_boot = 2; m_busy = 0; m_doomed = 0; m_pcv = 0;
    m_addr = 32'h0; m_pc = 32'h0; m_tgt = 32'h0;
  endtask

  task automatic model_edge();
    bit          may_go;
    logic [31:0] tgt_now;
    may_go  = en && !st;
    tgt_now = (rt / 4) * 4;
    m_pcv   = 0;
    if (m_boot > 0) begin
      if (en) m_boot = m_boot - 1;
    end else if (!m_busy) begin
      if (rv) m_addr = tgt_now;
      if (may_go) m_busy = 1;
    end else if (ack) begin
      if (rv)            m_addr = tgt_now;
      else if (m_doomed) m_addr = m_tgt;
      else begin
        m_pc   = m_addr;
        m_pcv  = 1;
        m_addr = m_addr + 32'd4;
      end
      m_doomed = 0;
      m_busy   = may_go;
    end else if (rv) begin
      m_doomed = 1;
      m_tgt    = tgt_now;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 1'b0; st = 1'b0; rv = 1'b0; rt = '0; ack = 1'b0;
    rst8 = 1'b0; en8 = 1'b0; st8 = 1'b0; rv8 = 1'b0; rt8 = '0; ack8 = 1'b0;

    //    en st rv rt         ack  req addr        pc          pcv
    add(1, 0, 1, 32'h700, 0,   0, 32'h000, 32'h000, 0); // boot, redirect ignored
    add(1, 0, 1, 32'h700, 0,   0, 32'h000, 32'h000, 0); // boot done -> idle
    add(1, 0, 0, 32'h0,   0,   1, 32'h000, 32'h000, 0); // first request
    add(1, 0, 0, 32'h0,   1,   1, 32'h004, 32'h000, 1); // ack same cycle
    add(1, 0, 0, 32'h0,   1,   1, 32'h008, 32'h004, 1); // no bubble
    add(1, 1, 0, 32'h0,   0,   1, 32'h008, 32'h004, 0); // stall while waiting
    add(1, 1, 0, 32'h0,   0,   1, 32'h008, 32'h004, 0);
    add(1, 1, 0, 32'h0,   1,   0, 32'h00C, 32'h008, 1); // ack, stalled -> idle
    add(1, 1, 0, 32'h0,   0,   0, 32'h00C, 32'h008, 0); // no req while stalled
    add(1, 0, 0, 32'h0,   0,   1, 32'h00C, 32'h008, 0); // stall drops -> req
    add(1, 0, 1, 32'h100, 0,   1, 32'h00C, 32'h008, 0); // redirect while waiting
    add(1, 0, 0, 32'h0,   1,   1, 32'h100, 32'h008, 0); // killed ack
    add(1, 0, 0, 32'h0,   1,   1, 32'h104, 32'h100, 1); // on target
    add(1, 0, 1, 32'h200, 0,   1, 32'h104, 32'h100, 0); // two redirects waiting
    add(1, 0, 1, 32'h300, 0,   1, 32'h104, 32'h100, 0);
    add(1, 0, 0, 32'h0,   1,   1, 32'h300, 32'h100, 0); // last target wins
    add(1, 0, 1, 32'h400, 1,   1, 32'h400, 32'h100, 0); // redirect with ack
    add(1, 0, 0, 32'h0,   1,   1, 32'h404, 32'h400, 1);
    add(1, 0, 1, 32'h503, 1,   1, 32'h500, 32'h400, 0); // target aligned
    add(1, 0, 0, 32'h0,   1,   1, 32'h504, 32'h500, 1);
    add(0, 0, 0, 32'h0,   1,   0, 32'h508, 32'h504, 1); // disabled -> idle
    add(0, 0, 1, 32'h600, 0,   0, 32'h600, 32'h504, 0); // redirect in idle
    add(1, 0, 0, 32'h0,   0,   1, 32'h600, 32'h504, 0);
    add(0, 0, 0, 32'h0,   0,   1, 32'h600, 32'h504, 0); // enable drop keeps req
    add(0, 0, 0, 32'h0,   1,   0, 32'h604, 32'h600, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk4("reset", 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;

    // Table
    foreach (vecs[i]) begin
      en = vecs[i].en; st = vecs[i].st; rv = vecs[i].rv; rt = vecs[i].rt; ack = vecs[i].ack;
      @(posedge clk); #1;
      chk4($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_pcv);
    end

    // Async reset in the middle of a request
    en = 1'b1; st = 1'b0; rv = 1'b0; ack = 1'b0;
    @(posedge clk); #1;
    chk4("pre_rst", 1'b1, 32'h604, 32'h600, 1'b0);
    #3 rst = 1'b0;
    #1 chk4("async_rst", 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk4("rst_hold", 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk4($sformatf("reboot%0d", k), k == 3, 32'h0, 32'h0, 1'b0);
    end

    // 8-bit instance: wrap and alignment
    rst8 = 1'b1; en8 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk8($sformatf("w8_boot%0d", k), k == 3, 8'hFC, 8'hFC, 1'b0);
    end
    ack8 = 1'b1;
    @(posedge clk); #1; chk8("w8_wrap", 1'b1, 8'h00, 8'hFC, 1'b1);
    ack8 = 1'b0; rv8 = 1'b1; rt8 = 8'h13;
    @(posedge clk); #1; chk8("w8_redir", 1'b1, 8'h00, 8'hFC, 1'b0);
    ack8 = 1'b1; rv8 = 1'b0;
    @(posedge clk); #1; chk8("w8_kill", 1'b1, 8'h10, 8'hFC, 1'b0);
    @(posedge clk); #1; chk8("w8_tgt", 1'b1, 8'h14, 8'h10, 1'b1);

    // Randomized run against the model
    rst = 1'b0; en = 1'b0; st = 1'b0; rv = 1'b0; ack = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 99) < 85);
      st  = ($urandom_range(0, 99) < 20);
      rv  = ($urandom_range(0, 99) < 10);
      rt  = $urandom;
      ack = ($urandom_range(0, 99) < 50);
      @(posedge clk);
      model_edge();
      #1;
      chk4($sformatf("rnd%0d", i), m_busy, m_addr, m_pc, m_pcv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
